// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the pipeline hazard controller
package cpu_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [1:0] {
        HALT_RUN   = 2'd0,
        HALT_DRAIN = 2'd1,
        HALT_STOP  = 2'd2
    } halt_state_e;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - EX operand forwarding select for one source register
module fwd_select
    import cpu_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              exmem_valid_i,
    input  logic              exmem_writes_i,
    input  logic              exmem_is_load_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_valid_i,
    input  logic              memwb_writes_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output logic [1:0]        sel_o
);

    // A load in EX/MEM has no data yet; the load-use stall covers that case.
    always_comb begin
        sel_o = FWD_IDEX;
        if (exmem_valid_i && exmem_writes_i && !exmem_is_load_i &&
            (exmem_rd_i != '0) && (exmem_rd_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_valid_i && memwb_writes_i &&
                     (memwb_rd_i != '0) && (memwb_rd_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline hazard, forwarding and halt controller
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_writes,
    input  logic              id_is_load,
    input  logic              id_is_halt,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              byp_id_a,
    output logic              byp_id_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              writes;
        logic              is_load;
        logic              is_halt;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } shadow_t;

    shadow_t          id_entry, idex_q, exmem_q, memwb_q;
    halt_state_e      state_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             freeze, branch_flush, lu_stall, load_use;
    logic             halt_enter, halt_leave;
    logic [1:0]       fwd_a_raw, fwd_b_raw;
    logic             unused_shadow;

    assign id_entry = '{valid: id_valid, rd: id_rd, writes: id_writes, is_load: id_is_load,
                        is_halt: id_is_halt, rs1: id_rs1, rs2: id_rs2};

    assign load_use = id_valid && idex_q.valid && idex_q.is_load && (idex_q.rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == idex_q.rd)) ||
                       (id_uses_rs2 && (id_rs2 == idex_q.rd)));

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        freeze       = 1'b0;
        branch_flush = 1'b0;
        lu_stall     = 1'b0;
        if (!reset) begin
            if (state_q == HALT_STOP) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            end else if (mem_busy && exmem_q.valid) begin
                freeze = 1'b1;
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            end else if (state_q == HALT_DRAIN) begin
                // Younger instructions are squashed while the halt walks out.
                pc_en       = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                branch_flush = 1'b1;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
            end else if (load_use) begin
                lu_stall    = 1'b1;
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign halt_enter = id_valid && id_is_halt && idex_en && !idex_bubble;
    assign halt_leave = memwb_q.valid && memwb_q.is_halt && memwb_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            state_q     <= HALT_RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (idex_en) begin
                idex_q <= idex_bubble ? '0 : id_entry;
            end
            if (exmem_en) begin
                exmem_q <= idex_q;
            end
            if (memwb_en) begin
                memwb_q <= exmem_q;
            end
            case (state_q)
                HALT_RUN: begin
                    if (halt_enter) begin
                        state_q <= HALT_DRAIN;
                    end
                end
                HALT_DRAIN: begin
                    if (halt_leave) begin
                        state_q  <= HALT_STOP;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= HALT_STOP;
                end
            endcase
            if ((freeze || lu_stall) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i          (idex_q.rs1),
        .exmem_valid_i  (exmem_q.valid),
        .exmem_writes_i (exmem_q.writes),
        .exmem_is_load_i(exmem_q.is_load),
        .exmem_rd_i     (exmem_q.rd),
        .memwb_valid_i  (memwb_q.valid),
        .memwb_writes_i (memwb_q.writes),
        .memwb_rd_i     (memwb_q.rd),
        .sel_o          (fwd_a_raw)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i          (idex_q.rs2),
        .exmem_valid_i  (exmem_q.valid),
        .exmem_writes_i (exmem_q.writes),
        .exmem_is_load_i(exmem_q.is_load),
        .exmem_rd_i     (exmem_q.rd),
        .memwb_valid_i  (memwb_q.valid),
        .memwb_writes_i (memwb_q.writes),
        .memwb_rd_i     (memwb_q.rd),
        .sel_o          (fwd_b_raw)
    );

    assign fwd_a    = reset ? FWD_IDEX : fwd_a_raw;
    assign fwd_b    = reset ? FWD_IDEX : fwd_b_raw;
    assign byp_id_a = !reset && memwb_q.valid && memwb_q.writes && (memwb_q.rd != '0) &&
                      (memwb_q.rd == id_rs1);
    assign byp_id_b = !reset && memwb_q.valid && memwb_q.writes && (memwb_q.rd != '0) &&
                      (memwb_q.rd == id_rs2);

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    assign unused_shadow = ^{memwb_q.rs1, memwb_q.rs2, memwb_q.is_load};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - vector/scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] ALU = 4'b1100;
    localparam logic [3:0] LD  = 4'b1110;
    localparam logic [3:0] ST  = 4'b1000;
    localparam logic [3:0] HLT = 4'b1001;
    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] STL = 5'b00111;
    localparam logic [4:0] DRN = 5'b01111;
    localparam logic [4:0] OFF = 5'b00000;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_writes, id_is_load, id_is_halt;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic id_uses_rs1, id_uses_rs2, ex_branch_taken, mem_busy;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic byp_id_a, byp_id_b, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_flush, s_idex_bubble;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic s_byp_id_a, s_byp_id_b, s_halted;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_AW(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_writes(id_writes),
        .id_is_load(id_is_load), .id_is_halt(id_is_halt), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_en(pc_en),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .byp_id_a(byp_id_a), .byp_id_b(byp_id_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.REG_AW(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_writes(id_writes),
        .id_is_load(id_is_load), .id_is_halt(id_is_halt), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .pc_en(s_pc_en),
        .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .byp_id_a(s_byp_id_a), .byp_id_b(s_byp_id_b), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic [4:0]  en;
        logic        fl;
        logic        bub;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  byp;
        logic        h;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] q;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [1:0] u;
        logic       br;
        logic       mb;
        obs_t       exp;
    } vec_t;

    vec_t  vecs[$];
    obs_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic void add(string nm, logic rst, logic [3:0] q, int rs1, int rs2, int rd,
                                logic [1:0] u, logic br, logic mb, logic [4:0] en, logic fl,
                                logic bub, int fa, int fb, logic [1:0] byp, logic h, int sc, int fc);
        vec_t v;
        v.name = nm; v.rst = rst; v.q = q;
        v.rs1 = 4'(rs1); v.rs2 = 4'(rs2); v.rd = 4'(rd);
        v.u = u; v.br = br; v.mb = mb;
        v.exp = '{en: en, fl: fl, bub: bub, fa: 2'(fa), fb: 2'(fb), byp: byp, h: h,
                  sc: 16'(sc), fc: 16'(fc)};
        vecs.push_back(v);
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.en  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
        o.fl  = ifid_flush;
        o.bub = idex_bubble;
        o.fa  = fwd_a;
        o.fb  = fwd_b;
        o.byp = {byp_id_a, byp_id_b};
        o.h   = halted;
        o.sc  = stall_cnt;
        o.fc  = flush_cnt;
        return o;
    endfunction

    task automatic drive(input logic rst, input logic [3:0] q, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [3:0] rd, input logic [1:0] u,
                         input logic br, input logic mb);
        reset = rst;
        {id_valid, id_writes, id_is_load, id_is_halt} = q;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        {id_uses_rs1, id_uses_rs2} = u;
        ex_branch_taken = br;
        mem_busy = mb;
    endtask

    task automatic check_next();
        obs_t  e;
        obs_t  g;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = observe();
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got en=%b fl=%b bub=%b fa=%0d fb=%0d byp=%b halted=%b stall=%0d flush=%0d; want en=%b fl=%b bub=%b fa=%0d fb=%0d byp=%b halted=%b stall=%0d flush=%0d",
                     nm, g.en, g.fl, g.bub, g.fa, g.fb, g.byp, g.h, g.sc, g.fc,
                     e.en, e.fl, e.bub, e.fa, e.fb, e.byp, e.h, e.sc, e.fc);
        end
    endtask

    task automatic check_val(string nm, int got, int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    initial begin
        drive(1'b1, NOP, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        //   name           rst q    rs1 rs2 rd u      br mb  en  fl bub fa fb byp    h  sc fc
        add("reset",        1, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("ld_r3",        0, LD,  2, 0, 3, 2'b10, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("lu_stall",     0, ALU, 3, 1, 4, 2'b11, 0, 0, STL, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        add("lu_release",   0, ALU, 3, 1, 4, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        add("lu_fwd_wb",    0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 2, 0, 2'b00, 0, 1, 0);
        add("add_r2",       0, ALU, 1, 1, 2, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        add("sub_r5",       0, ALU, 2, 2, 5, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        add("fwd_exmem",    0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 1, 1, 2'b00, 0, 1, 0);
        add("byp_a_r2",     0, ALU, 2, 7, 8, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b10, 0, 1, 0);
        add("ld_r0",        0, LD,  5, 0, 0, 2'b10, 0, 0, ALL, 0, 0, 0, 0, 2'b10, 0, 1, 0);
        add("r0_no_stall",  0, ALU, 0, 0, 9, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        add("ld_r7",        0, LD,  1, 0, 7, 2'b10, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        add("br_over_lu",   0, ALU, 7, 2, 3, 2'b11, 1, 0, ALL, 1, 1, 0, 0, 2'b00, 0, 1, 0);
        add("post_branch",  0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        add("reset2",       1, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        add("add_r6",       0, ALU, 1, 0, 6, 2'b10, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("store",        0, ST,  6, 4, 0, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("st_fwd",       0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 1, 0, 2'b00, 0, 0, 0);
        add("freeze1",      0, ALU, 6, 3, 2, 2'b11, 0, 1, OFF, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        add("freeze2",      0, ALU, 6, 3, 2, 2'b11, 0, 1, OFF, 0, 0, 0, 0, 2'b10, 0, 1, 0);
        add("freeze3",      0, ALU, 6, 3, 2, 2'b11, 0, 1, OFF, 0, 0, 0, 0, 2'b10, 0, 2, 0);
        add("freeze4",      0, ALU, 6, 3, 2, 2'b11, 0, 1, OFF, 0, 0, 0, 0, 2'b10, 0, 3, 0);
        add("unfreeze",     0, ALU, 6, 3, 2, 2'b11, 0, 0, ALL, 0, 0, 0, 0, 2'b10, 0, 4, 0);
        add("st_no_fwd",    0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 4, 0);
        add("add_r1",       0, ALU, 2, 0, 1, 2'b10, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 4, 0);
        add("halt_id",      0, HLT, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 2, 0, 2'b00, 0, 4, 0);
        add("drain1",       0, ALU, 1, 0, 5, 2'b10, 0, 0, DRN, 1, 1, 0, 0, 2'b00, 0, 4, 0);
        add("drain2_r1wb",  0, NOP, 1, 0, 0, 2'b10, 0, 0, DRN, 1, 1, 0, 0, 2'b10, 0, 4, 0);
        add("drain3",       0, NOP, 0, 0, 0, 2'b00, 0, 0, DRN, 1, 1, 0, 0, 2'b00, 0, 4, 0);
        add("halted",       0, NOP, 0, 0, 0, 2'b00, 0, 0, OFF, 0, 0, 0, 0, 2'b00, 1, 4, 0);
        add("halted_busy",  0, NOP, 0, 0, 0, 2'b00, 1, 1, OFF, 0, 0, 0, 0, 2'b00, 1, 4, 0);
        add("halted_hold",  0, NOP, 0, 0, 0, 2'b00, 0, 0, OFF, 0, 0, 0, 0, 2'b00, 1, 4, 0);
        add("reset3",       1, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 1, 4, 0);
        add("br_kills_halt",0, HLT, 0, 0, 0, 2'b00, 1, 0, ALL, 1, 1, 0, 0, 2'b00, 0, 0, 0);
        add("nohalt1",      0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        add("nohalt2",      0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        add("nohalt3",      0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        add("halt2_id",     0, HLT, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        add("halt2_drain",  0, NOP, 0, 0, 0, 2'b00, 0, 0, DRN, 1, 1, 0, 0, 2'b00, 0, 0, 1);
        add("reset_drain",  1, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        add("after_rst1",   0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("after_rst2",   0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("after_rst3",   0, NOP, 0, 0, 0, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("ld_r5",        0, LD,  0, 0, 5, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("unused_src",   0, ALU, 5, 0, 6, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("ld_r9",        0, LD,  0, 0, 9, 2'b00, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        add("lu_rs2",       0, ALU, 0, 9, 1, 2'b01, 0, 0, STL, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        add("lu_rs2_rel",   0, ALU, 0, 9, 1, 2'b01, 0, 0, ALL, 0, 0, 0, 0, 2'b00, 0, 1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].q, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u,
                  vecs[i].br, vecs[i].mb);
            exp_q.push_back(vecs[i].exp);
            name_q.push_back(vecs[i].name);
            #2;
            check_next();
        end

        // Saturation: five freeze cycles against a 2-bit and a 16-bit counter.
        @(negedge clk); drive(1'b1, NOP, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, ALU, 0, 0, 1, 2'b00, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, NOP, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); drive(1'b0, NOP, 0, 0, 0, 2'b00, 1'b0, 1'b1);
        end
        #2;
        check_val("sat_freeze_en", int'({s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en}), 0);
        @(negedge clk); drive(1'b0, NOP, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        #2;
        check_val("sat_stall_cnt_w2", int'(s_stall_cnt), 3);
        check_val("sat_stall_cnt_w16", int'(stall_cnt), 5);
        check_val("sat_release_en", int'({s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en}), 31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have ports id_valid / id_writes / id_is_load / id_is_halt  input  1 each  decode-stage qualifiers.
REQ-006 SHALL have ports id_rs1 / id_rs2 / id_rd  input  REG_AW each  decode-stage register indices.
REQ-007 SHALL have ports id_uses_rs1 / id_uses_rs2  input  1 each  operand actually read.
REQ-008 SHALL have port ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have port mem_busy  input  1  data memory not ready for the op in MEM.
REQ-010 SHALL have ports pc_en / ifid_en / idex_en / exmem_en / memwb_en  output  1 each  pipeline-register enables.
REQ-011 SHALL have ports ifid_flush / idex_bubble  output  1 each  load NOP into IF/ID / ID/EX.
REQ-012 SHALL have ports fwd_a / fwd_b  output  2 each  EX operand select: 0 = ID/EX value, 1 = EX/MEM, 2 = MEM/WB.
REQ-013 SHALL have ports byp_id_a / byp_id_b  output  1 each  select WB data over regfile read in ID.
REQ-014 SHALL have port halted  output  1  sticky; program drained.
REQ-015 SHALL have ports stall_cnt / flush_cnt  output  CNT_W each  performance counters.

Function
REQ-016 SHALL keep shadow entries {valid, rd, writes, is_load, is_halt, rs1, rs2} for ID/EX, EX/MEM, MEM/WB, advanced with the same enables and bubbles as the datapath.
REQ-017 SHALL detect load-use when ID/EX is a valid load, its rd != 0, and rd matches id_rs1 (with id_uses_rs1) or id_rs2 (with id_uses_rs2).
REQ-018 SHALL, on load-use, drive pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle.
REQ-019 SHALL, on ex_branch_taken, drive ifid_flush=1 and idex_bubble=1 with pc_en=1: 2 wrong-path slots squashed, 0 extra stall cycles.
REQ-020 SHALL, while mem_busy=1 and EX/MEM holds a valid load or store, drive all five enables to 0 and flush/bubble to 0: full freeze, shadows held.
REQ-021 SHALL apply priority: reset > mem freeze > branch flush > load-use stall > advance.
REQ-022 SHALL, on simultaneous branch and load-use, flush without stalling.
REQ-023 SHALL set fwd_x=1 when EX/MEM is valid, writes, is not a load, rd != 0, and rd == the ID/EX source.
REQ-024 SHALL otherwise set fwd_x=2 when MEM/WB is valid, writes, rd != 0, and rd matches; otherwise fwd_x=0.
REQ-025 SHALL assert byp_id_x when MEM/WB is valid, writes, rd != 0, and rd == id_rsx.
REQ-026 SHALL run halt FSM RUN -> DRAIN -> HALTED.
REQ-027 SHALL leave RUN for DRAIN when a valid halt enters ID/EX without a same-cycle branch flush.
REQ-028 SHALL, in DRAIN, hold pc_en=0 and ifid_flush=1; older instructions complete.
REQ-029 SHALL leave DRAIN for HALTED in the cycle the halt entry leaves MEM/WB: 3 cycles absent freezes.
REQ-030 SHALL, in HALTED, drive all enables 0 and halted=1 until reset.
REQ-031 SHALL drop a halt in ID when a branch flush squashes it; FSM stays RUN.
REQ-032 SHALL increment stall_cnt on each load-use or freeze cycle and flush_cnt on each ex_branch_taken; both saturate at all-ones, no wrap.

Reset
REQ-033 SHALL clear all shadow valid bits, enter RUN, and clear halted, stall_cnt, flush_cnt.
REQ-034 SHALL drive enables=1, flush/bubble=0, fwd=0, byp=0 during and after reset.
REQ-035 SHALL let reset mid-DRAIN or mid-freeze abort immediately, with no residual stall.

Structure
REQ-036 SHALL place fwd-select encodings (FWD_IDEX, FWD_EXMEM, FWD_MEMWB) and halt FSM state encodings in shared package cpu_pkg.
REQ-037 SHALL implement the forwarding comparator as one sub-module fwd_select, instantiated once per operand.

Verification
REQ-038 SHALL cover: LOAD r3; ADD r4,r3,r1 -> exactly 1 bubble, then fwd_a=2, stall_cnt=1.
REQ-039 SHALL cover: ADD r2; SUB r5,r2,r2 -> fwd_a=fwd_b=1, no stall.
REQ-040 SHALL cover: branch taken with load-use pending in ID -> ifid_flush=1, idex_bubble=1, pc_en=1, stall_cnt unchanged, flush_cnt=1.
REQ-041 SHALL cover: STORE in MEM with mem_busy high 4 cycles -> all enables 0 for 4 cycles, stall_cnt=4, shadows unchanged.
REQ-042 SHALL cover: ADD r1; HALT -> halted=1 exactly 3 cycles after HALT enters ID/EX; r1 written; HALT behind taken branch never halts.
REQ-043 SHALL cover: CNT_W=2, 5 stalls -> stall_cnt saturates at 3.
